data_mem_dump_reader: RTL and testbench

Read-side counterpart of the external data-memory load port used around riscv_cpu. While the CPU is held in reset, it sweeps a word-aligned address range of data_mem, captures each ReadData word and streams it out over a valid/ready interface with its address. Used by benches and board tops to dump program results after a run, as the mirror image of preloading memory before one.

---
 rtl/data_mem_dump_reader_if.sv | 22 ++
 rtl/data_mem_dump_reader.sv | 127 ++++++++++++
 tb/tb_data_mem_dump_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_dump_reader_if.sv
// Word stream carried out of the data-memory dump reader: one address/data pair per
// valid/ready transfer.
interface data_mem_dump_reader_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [31:0] dump_adr;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_adr,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_adr,
        output dump_ready
    );
endinterface

// File: rtl/data_mem_dump_reader.sv
// Holds the CPU in reset, sweeps a word-aligned range of data_mem through the external
// address port and streams each word out with its byte address.
module data_mem_dump_reader #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_adr,
    input  logic [CNT_W-1:0]       word_cnt,
    input  logic [31:0]            ReadData,
    output logic                   cpu_hold,
    output logic [31:0]            Ext_DataAdr,
    output logic                   busy,
    output logic                   done,
    data_mem_dump_reader_if.master dump
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ADDR,
        CAPTURE,
        SEND,
        FIN
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(HOLD_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [3:0]         settle_cnt;
    logic [CNT_W-1:0]   remaining;
    logic               xfer;
    logic               active_next;
    logic               last_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        xfer        = 1'b0;
        last_word   = (remaining == CNT_W'(1));
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (word_cnt == '0) ? FIN : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    next_state = ADDR;
                end
            end
            ADDR:    next_state = CAPTURE;
            CAPTURE: next_state = SEND;
            SEND: begin
                if (dump.dump_valid && dump.dump_ready) begin
                    xfer       = 1'b1;
                    next_state = last_word ? FIN : ADDR;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        active_next = (next_state == SETTLE) || (next_state == ADDR) ||
                      (next_state == CAPTURE) || (next_state == SEND);
    end

    // Status outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_hold        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            Ext_DataAdr     <= 32'd0;
            settle_cnt      <= 4'd0;
            remaining       <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_data  <= 32'd0;
            dump.dump_adr   <= 32'd0;
        end else begin
            cpu_hold <= active_next;
            busy     <= active_next;
            done     <= (next_state == FIN);
            case (state)
                IDLE: begin
                    if (start && (word_cnt != '0)) begin
                        Ext_DataAdr <= base_adr & 32'hFFFF_FFFC;
                        remaining   <= word_cnt;
                        settle_cnt  <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    dump.dump_data  <= ReadData;
                    dump.dump_adr   <= Ext_DataAdr;
                    dump.dump_valid <= 1'b1;
                end
                SEND: begin
                    if (xfer) begin
                        dump.dump_valid <= 1'b0;
                        remaining       <= remaining - CNT_W'(1);
                        if (!last_word) begin
                            Ext_DataAdr <= Ext_DataAdr + 32'd4;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dump_reader.sv
// Scoreboard bench for data_mem_dump_reader: stimulus pushes expected words, a negedge
// monitor pops and compares every transfer and checks stall stability.
module tb_data_mem_dump_reader;

    localparam int HOLD  = 2;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       base_adr;
    logic [CNT_W-1:0]  word_cnt;
    logic [31:0]       read_data;
    logic              cpu_hold;
    logic [31:0]       ext_adr;
    logic              busy;
    logic              done;

    data_mem_dump_reader_if dif ();

    data_mem_dump_reader #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_adr    (base_adr),
        .word_cnt    (word_cnt),
        .ReadData    (read_data),
        .cpu_hold    (cpu_hold),
        .Ext_DataAdr (ext_adr),
        .busy        (busy),
        .done        (done),
        .dump        (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0010: mem_read = 32'hAAAA_0001;
            32'h0000_0014: mem_read = 32'hAAAA_0002;
            32'h0000_0018: mem_read = 32'hAAAA_0003;
            32'h0000_0020: mem_read = 32'hDDDD_0001;
            32'h0000_0024: mem_read = 32'hDDDD_0002;
            32'h0000_0040: mem_read = 32'hCCCC_0001;
            32'h0000_0044: mem_read = 32'hCCCC_0002;
            32'h0000_0048: mem_read = 32'hCCCC_0003;
            32'h0000_004C: mem_read = 32'hCCCC_0004;
            32'hFFFF_FFF8: mem_read = 32'hBBBB_0001;
            32'hFFFF_FFFC: mem_read = 32'hBBBB_0002;
            32'h0000_0000: mem_read = 32'hBBBB_0003;
            default:       mem_read = 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb read_data = mem_read(ext_adr);

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic [31:0]   exp_adr[$];
    logic [31:0]   exp_data[$];
    int            vrise[$];
    int            done_count = 0;
    int            done_cyc = 0;
    int            hold_rise_cyc = 0;
    int            hold_fall_cyc = 0;
    bit            hold_seen = 0;
    logic          prev_hold = 1'b0;
    logic          prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: transfers pop the scoreboard, stalls are held against its front entry.
    always @(negedge clk) begin
        if (cpu_hold && !prev_hold) hold_rise_cyc = cyc;
        if (!cpu_hold && prev_hold) hold_fall_cyc = cyc;
        if (cpu_hold) hold_seen = 1;
        if (dif.dump_valid && !prev_valid) vrise.push_back(cyc);
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (dif.dump_valid) begin
            if (exp_adr.size() == 0) begin
                checkOutput("unexpected_word", dif.dump_adr, 32'hFFFF_FFFF);
            end else begin
                checkOutput("word_adr", dif.dump_adr, exp_adr[0]);
                checkOutput("word_data", dif.dump_data, exp_data[0]);
                if (dif.dump_ready) begin
                    void'(exp_adr.pop_front());
                    void'(exp_data.pop_front());
                end else begin
                    checkOutput("stall_cpu_hold", 32'(cpu_hold), 32'd1);
                end
            end
        end
        prev_hold  = cpu_hold;
        prev_valid = dif.dump_valid;
    end

    task automatic pushExp(input logic [31:0] a, input logic [31:0] d);
        exp_adr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic clearStats();
        @(posedge clk);
        #1;
        vrise.delete();
        done_count = 0;
        hold_seen  = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic [CNT_W-1:0] c);
        base_adr  = b;
        word_cnt  = c;
        start_cyc = cyc;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic waitDone(input string name, input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        #1;
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic waitWord(input string name, input logic [31:0] a, input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk);
            #1;
            if (dif.dump_valid && dif.dump_adr == a) seen = 1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        base_adr       = 32'd0;
        word_cnt       = '0;
        dif.dump_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(dif.dump_valid), 32'd0);
        checkOutput("rst_ext_adr", ext_adr, 32'd0);
        checkOutput("rst_dump_data", dif.dump_data, 32'd0);
        checkOutput("rst_dump_adr", dif.dump_adr, 32'd0);
        reset = 1'b1;

        $display("[TB] basic dump");
        clearStats();
        pushExp(32'h10, 32'hAAAA_0001);
        pushExp(32'h14, 32'hAAAA_0002);
        pushExp(32'h18, 32'hAAAA_0003);
        applyStimulus(32'h12, 16'd3);
        waitDone("basic_done", 60);
        checkOutput("basic_hold_rise", 32'(hold_rise_cyc - start_cyc), 32'd1);
        checkOutput("basic_nwords", 32'(vrise.size()), 32'd3);
        if (vrise.size() == 3) begin
            checkOutput("basic_first_valid", 32'(vrise[0] - start_cyc), 32'(HOLD + 3));
            checkOutput("basic_gap1", 32'(vrise[1] - vrise[0]), 32'd3);
            checkOutput("basic_gap2", 32'(vrise[2] - vrise[1]), 32'd3);
        end
        checkOutput("basic_done_time", 32'(done_cyc - start_cyc), 32'(HOLD + 10));
        checkOutput("basic_hold_fall", 32'(hold_fall_cyc - start_cyc), 32'(HOLD + 10));
        checkOutput("basic_done_count", 32'(done_count), 32'd1);
        checkOutput("basic_queue_empty", 32'(exp_adr.size()), 32'd0);

        $display("[TB] zero count");
        clearStats();
        applyStimulus(32'h100, 16'd0);
        waitDone("zero_done", 10);
        checkOutput("zero_done_time", 32'(done_cyc - start_cyc), 32'd1);
        checkOutput("zero_hold_seen", 32'(hold_seen), 32'd0);
        checkOutput("zero_no_valid", 32'(vrise.size()), 32'd0);

        $display("[TB] back-pressure");
        clearStats();
        pushExp(32'h10, 32'hAAAA_0001);
        pushExp(32'h14, 32'hAAAA_0002);
        pushExp(32'h18, 32'hAAAA_0003);
        applyStimulus(32'h12, 16'd3);
        waitWord("bp_word2_seen", 32'h14, 40);
        dif.dump_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dif.dump_ready = 1'b1;
        waitDone("bp_done", 60);
        checkOutput("bp_nwords", 32'(vrise.size()), 32'd3);
        checkOutput("bp_queue_empty", 32'(exp_adr.size()), 32'd0);
        checkOutput("bp_done_count", 32'(done_count), 32'd1);

        $display("[TB] wrap-around");
        clearStats();
        pushExp(32'hFFFF_FFF8, 32'hBBBB_0001);
        pushExp(32'hFFFF_FFFC, 32'hBBBB_0002);
        pushExp(32'h0000_0000, 32'hBBBB_0003);
        applyStimulus(32'hFFFF_FFF8, 16'd3);
        waitDone("wrap_done", 60);
        checkOutput("wrap_queue_empty", 32'(exp_adr.size()), 32'd0);

        $display("[TB] reset mid-dump");
        clearStats();
        pushExp(32'h40, 32'hCCCC_0001);
        pushExp(32'h44, 32'hCCCC_0002);
        pushExp(32'h48, 32'hCCCC_0003);
        pushExp(32'h4C, 32'hCCCC_0004);
        applyStimulus(32'h40, 16'd4);
        waitWord("rst_word2_seen", 32'h44, 40);
        dif.dump_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("midrst_valid", 32'(dif.dump_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        dif.dump_ready = 1'b1;
        exp_adr.delete();
        exp_data.delete();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_no_done", 32'(done_count), 32'd0);

        clearStats();
        pushExp(32'h40, 32'hCCCC_0001);
        pushExp(32'h44, 32'hCCCC_0002);
        pushExp(32'h48, 32'hCCCC_0003);
        pushExp(32'h4C, 32'hCCCC_0004);
        applyStimulus(32'h40, 16'd4);
        waitDone("after_rst_done", 80);
        checkOutput("after_rst_queue_empty", 32'(exp_adr.size()), 32'd0);
        checkOutput("after_rst_done_count", 32'(done_count), 32'd1);

        $display("[TB] start while busy");
        clearStats();
        pushExp(32'h20, 32'hDDDD_0001);
        pushExp(32'h24, 32'hDDDD_0002);
        applyStimulus(32'h20, 16'd2);
        base_adr = 32'h80;
        word_cnt = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitWord("busy_word2_seen", 32'h24, 40);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("busy_done_count", 32'(done_count), 32'd1);
        checkOutput("busy_nwords", 32'(vrise.size()), 32'd2);
        checkOutput("busy_queue_empty", 32'(exp_adr.size()), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
